// File: rtl/regfile_mp_if.sv
// Bundles the regfile_mp read, write-back, allocation and status signals.
// The master side is the core pipeline; the slave side is the register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 3
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;

    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;

    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;

    logic [AW:0]         busy_count;

    modport master (
        output rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_count
    );

    modport slave (
        input  rd_addr, we0, waddr0, wdata0, we1, waddr1, wdata1,
               alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_count
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with an integrated busy scoreboard.
// Register 0 reads zero and is never busy. busy_count tracks popcount(busy).
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through on read ports,
// with the write's busy clear also visible in that cycle.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 3
) (
    input logic          clk,
    input logic          i_reset,
    regfile_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      busy_count_reg;
    logic [AW:0]      busy_count_next;

    logic wr0_ok;
    logic wr1_ok;
    logic alloc_ok;
    logic cnt_inc;
    logic cnt_dec0;
    logic cnt_dec1;

    // Writes and allocations to register 0 are dropped at the source.
    assign wr0_ok   = bus.we0 && (bus.waddr0 != '0);
    assign wr1_ok   = bus.we1 && (bus.waddr1 != '0);
    assign alloc_ok = bus.alloc_en && (bus.alloc_addr != '0);

    // Next busy vector: clears from both write ports, then alloc overrides.
    always_comb begin
        busy_next = busy_reg;
        if (wr0_ok) busy_next[bus.waddr0] = 1'b0;
        if (wr1_ok) busy_next[bus.waddr1] = 1'b0;
        if (alloc_ok) busy_next[bus.alloc_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Incremental popcount: count only real 0->1 and 1->0 transitions,
    // and a register cleared by both ports only once.
    always_comb begin
        cnt_inc  = alloc_ok && !busy_reg[bus.alloc_addr];
        cnt_dec0 = wr0_ok && busy_reg[bus.waddr0]
                   && !(alloc_ok && (bus.alloc_addr == bus.waddr0));
        cnt_dec1 = wr1_ok && busy_reg[bus.waddr1]
                   && !(alloc_ok && (bus.alloc_addr == bus.waddr1))
                   && !(wr0_ok && (bus.waddr0 == bus.waddr1));
        busy_count_next = busy_count_reg
                          + {{AW{1'b0}}, cnt_inc}
                          - {{AW{1'b0}}, cnt_dec0}
                          - {{AW{1'b0}}, cnt_dec1};
    end

    // Register array; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            if (wr0_ok) regs_reg[bus.waddr0] <= bus.wdata0;
            if (wr1_ok) regs_reg[bus.waddr1] <= bus.wdata1;
        end
    end

    // Busy scoreboard and its population count.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            busy_reg       <= '0;
            busy_count_reg <= '0;
        end else begin
            busy_reg       <= busy_next;
            busy_count_reg <= busy_count_next;
        end
    end

    assign bus.busy_count = busy_count_reg;

    // Combinational read ports; outputs are forced to zero while in reset.
    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            busy;

            assign addr = bus.rd_addr[gi*AW +: AW];

            // Array lookup, optional write-through, reset gating.
            always_comb begin
                data = regs_reg[addr];
                busy = busy_reg[addr];
`ifdef REGFILE_BYPASS_EN
                if (addr != '0) begin
                    if (wr1_ok && (bus.waddr1 == addr)) begin
                        data = bus.wdata1;
                        busy = alloc_ok && (bus.alloc_addr == addr);
                    end else if (wr0_ok && (bus.waddr0 == addr)) begin
                        data = bus.wdata0;
                        busy = alloc_ok && (bus.alloc_addr == addr);
                    end
                end
`endif
                if (!i_reset) begin
                    data = '0;
                    busy = 1'b0;
                end
            end

            assign bus.rd_data[gi*XLEN +: XLEN] = data;
            assign bus.rd_busy[gi]              = busy;
        end
    endgenerate
endmodule
